multimode_timer: RTL
====================

# multimode_timer

Parametrised successor to the single-mode countdown timer: one block providing one-shot countdown, auto-reload countdown, and count-up stopwatch, with a configurable tick divider and minute ceiling. It sits between the board buttons and switches and the `dspl_drv_NexysA7` 8-digit display driver, which it instantiates internally. It also exposes the raw count and status flags for other logic and for verification.

## Interface
Parameters:
- `TICK_DIV`, default 100_000_000: `clock` cycles per 1 s tick; must be ≥ 2; benches use small values.
- `MAX_MIN`, default 99: minute ceiling; must be ≤ 99.

Ports:
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  level; acts on its rising edge.
- `stop`   in  1  level; acts on its rising edge.
- `pause`  in  1  level; acts on its rising edge.
- `mode`   in  2  00 = one-shot countdown; 01 = repeat countdown; 10 = stopwatch; 11 = treated as 00.
- `min`    in  7  countdown preset, minutes.
- `sec`    in  7  countdown preset, seconds.
- `done`   out 1  level high in DONE; one-cycle pulse on a repeat reload.
- `running` out 1  high in RUN.
- `paused` out 1  high in PAUSE.
- `min_out` out 7  current minutes.
- `sec_out` out 7  current seconds.
- `an`     out 8  display anodes, from the driver.
- `dec_cat` out 8  display cathodes, from the driver.

## Operation
- **Edge detection:** one register per `start`/`stop`/`pause`. An event is valid in a cycle when the input is 1 and its register holds 0. Registers reset to 0.
- **States:** IDLE, RUN, PAUSE, DONE. Reset → IDLE, count 00:00, prescaler 0.
- **IDLE, value tracking:** the count tracks the load value every cycle.
  - Countdown load value = saturated presets: `sec` > 59 → 59; `min` > `MAX_MIN` → `MAX_MIN`.
  - Stopwatch load value = 00:00.
- **IDLE, transitions:** start event → RUN, prescaler cleared, and the load value is latched as the reload value.
  - Exception: in a countdown mode with load value 00:00, start is ignored.
  - Start and stop in the same cycle: stop wins, stay IDLE.
- **RUN priority:** stop → IDLE > terminal action on tick > pause → PAUSE.
- **Prescaler:** counts 0..`TICK_DIV`-1 only in RUN. A tick is the cycle in which it equals `TICK_DIV`-1; it wraps to 0 on that tick.
  - In PAUSE it holds, preserving the sub-second phase.
- **Countdown tick:**
  - sec ≠ 0 → sec−1.
  - sec = 0 → sec = 59, min−1.
  - The tick that produces 00:00:
    - mode 00 → DONE, count held at 00:00.
    - mode 01 → count reloads to the latched reload value on that same edge (00:00 is never displayed), `done` pulses for 1 cycle, state stays RUN.
- **Stopwatch tick:**
  - sec < 59 → sec+1.
  - sec = 59 → sec = 0, min+1.
  - The tick that produces `MAX_MIN`:59 → DONE, count held.
- **PAUSE:** pause or start event → RUN, prescaler resumes from its held value. Stop → IDLE; stop has priority.
- **DONE:** `done` = 1, count frozen. A start or stop event → IDLE.
- **Mode changes** are sampled only in IDLE. The latched mode is used in RUN, PAUSE and DONE.
- **Display:** digits 1–4 = sec units, sec tens, min units, min tens (binary mod/div 10).
  - Digit 3 has its decimal point on.
  - Digits 5–8 are disabled.
  - Each digit field is {enable, value[3:0], dp}.

## Timing
- **Event latency:** an input rising and sampled at edge N changes the state at edge N+1. `running`/`paused`/`done` are registered, or decoded from the state register.
- **First tick:** RUN entered at edge E → first tick update at edge E+`TICK_DIV`, then every `TICK_DIV` cycles.
- **Resume after pause:** pause at prescaler value p, then resume → next tick after `TICK_DIV`−p cycles of RUN.
- **Stop during RUN** in the same cycle as a tick: stop wins. No count update; the next edge returns to IDLE and reloads.
- **Reset mid-operation:** the next edge forces IDLE, 00:00, prescaler 0, edge registers 0, `done`/`running`/`paused` = 0. Display outputs follow the driver's reset values.
- **Counter widths:** min/sec are 7-bit unsigned. The prescaler is $clog2(`TICK_DIV`) bits. No arithmetic under- or overflow is reachable.

## Test plan
All scenarios use `TICK_DIV` = 4, `MAX_MIN` = 99.
- **One-shot countdown:** mode 00, preset 00:03, start pulse → `running` next edge; sec_out goes 2, 1, 0 at 4-cycle spacing; DONE with `done` = 1 and 00:00 held; a stop pulse returns to IDLE.
- **Saturation and borrow:** preset min = 120, sec = 75 → IDLE shows 99:59. Start, then after 60 ticks → 98:59; borrow checked at the 99:00 → 98:59 step.
- **Repeat countdown:** mode 01, preset 00:02 → sequence 02, 01, 02, 01…; `done` is high exactly 1 cycle at each reload; 00:00 never appears on sec_out.
- **Pause phase:** stopwatch, pause issued 2 cycles after a tick → count frozen for 10 cycles; resume → next increment exactly 2 RUN cycles later. A start pulse also resumes from PAUSE.
- **Stopwatch ceiling:** `MAX_MIN` = 1, run → 01:59 reached, then DONE; the count stays at 01:59 for 20 cycles.
- **Edge cases:**
  - Countdown preset 00:00 with start → remains IDLE.
  - Start and stop in the same cycle in IDLE → stays IDLE.
  - Holding start high → exactly one event.
  - Reset asserted mid-RUN → 00:00 and IDLE after one edge.

Source files
------------

// File: rtl/multimode_timer.sv
// Multi-mode minute/second timer: one-shot countdown, auto-reload countdown and stopwatch, plus a 4-digit display.
// Latency: a button edge sampled at edge N changes state at edge N+1; a count tick lands every TICK_DIV cycles of RUN.
// Backpressure: none; button edges are consumed or ignored in the cycle they are seen, and the display scans freely.

module multimode_timer #(
    parameter int TICK_DIV = 100_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    input  logic [6:0] min,
    input  logic [6:0] sec,
    output logic       done,
    output logic       running,
    output logic       paused,
    output logic [6:0] min_out,
    output logic [6:0] sec_out,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    localparam int             PW      = $clog2(TICK_DIV);
    localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [6:0]     MAXM    = 7'(MAX_MIN);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [6:0]    min_r, sec_r;
    logic [6:0]    rel_min, rel_sec;
    logic          lat_cd, lat_rep;
    logic          pulse_r;
    logic          start_q, stop_q, pause_q;

    logic          start_ev, stop_ev, pause_ev, tick;
    logic          cd_in, load_zero;
    logic [6:0]    sat_min, sat_sec, load_min, load_sec;
    logic [6:0]    cd_min, cd_sec, sw_min, sw_sec;
    logic          cd_zero, sw_ceil;

    assign start_ev = start & ~start_q;
    assign stop_ev  = stop  & ~stop_q;
    assign pause_ev = pause & ~pause_q;
    assign tick     = (pre == PRE_MAX);

    // Load value seen in IDLE: saturated presets for countdown, zero for stopwatch (mode 11 behaves as 00).
    always_comb begin
        sat_sec   = (sec > 7'd59) ? 7'd59 : sec;
        sat_min   = (min > MAXM)  ? MAXM  : min;
        cd_in     = (mode != 2'b10);
        load_min  = cd_in ? sat_min : 7'd0;
        load_sec  = cd_in ? sat_sec : 7'd0;
        load_zero = (load_min == 7'd0) && (load_sec == 7'd0);
    end

    // Next count for one countdown step (borrow across minutes) and one stopwatch step (carry).
    always_comb begin
        if (sec_r != 7'd0) begin
            cd_sec = sec_r - 7'd1;
            cd_min = min_r;
        end else begin
            cd_sec = 7'd59;
            cd_min = min_r - 7'd1;
        end
        if (sec_r < 7'd59) begin
            sw_sec = sec_r + 7'd1;
            sw_min = min_r;
        end else begin
            sw_sec = 7'd0;
            sw_min = min_r + 7'd1;
        end
        cd_zero = (cd_min == 7'd0) && (cd_sec == 7'd0);
        sw_ceil = (sw_min == MAXM) && (sw_sec == 7'd59);
    end

    // Control FSM with prescaler, count, reload latch and button edge registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            pre     <= '0;
            min_r   <= 7'd0;
            sec_r   <= 7'd0;
            rel_min <= 7'd0;
            rel_sec <= 7'd0;
            lat_cd  <= 1'b0;
            lat_rep <= 1'b0;
            pulse_r <= 1'b0;
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            pause_q <= 1'b0;
        end else begin
            start_q <= start;
            stop_q  <= stop;
            pause_q <= pause;
            pulse_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    min_r   <= load_min;
                    sec_r   <= load_sec;
                    lat_cd  <= cd_in;
                    lat_rep <= (mode == 2'b01);
                    pre     <= '0;
                    // A zero countdown preset would end immediately, so start is ignored for it.
                    if (start_ev && !stop_ev && !(cd_in && load_zero)) begin
                        state   <= S_RUN;
                        rel_min <= load_min;
                        rel_sec <= load_sec;
                    end
                end
                S_RUN: begin
                    if (stop_ev) begin
                        state <= S_IDLE;
                        min_r <= load_min;
                        sec_r <= load_sec;
                    end else if (tick) begin
                        pre <= '0;
                        if (lat_cd) begin
                            if (cd_zero && lat_rep) begin
                                // Reload on the same edge so 00:00 is never shown in repeat mode.
                                min_r   <= rel_min;
                                sec_r   <= rel_sec;
                                pulse_r <= 1'b1;
                            end else begin
                                min_r <= cd_min;
                                sec_r <= cd_sec;
                                if (cd_zero) begin
                                    state <= S_DONE;
                                end else if (pause_ev) begin
                                    state <= S_PAUSE;
                                end
                            end
                        end else begin
                            min_r <= sw_min;
                            sec_r <= sw_sec;
                            if (sw_ceil) begin
                                state <= S_DONE;
                            end else if (pause_ev) begin
                                state <= S_PAUSE;
                            end
                        end
                    end else if (pause_ev) begin
                        // Prescaler holds so the sub-second phase survives the pause.
                        state <= S_PAUSE;
                    end else begin
                        pre <= pre + 1'b1;
                    end
                end
                S_PAUSE: begin
                    if (stop_ev) begin
                        state <= S_IDLE;
                        min_r <= load_min;
                        sec_r <= load_sec;
                    end else if (pause_ev || start_ev) begin
                        state <= S_RUN;
                    end
                end
                default: begin
                    if (start_ev || stop_ev) begin
                        state <= S_IDLE;
                        min_r <= load_min;
                        sec_r <= load_sec;
                    end
                end
            endcase
        end
    end

    assign running = (state == S_RUN);
    assign paused  = (state == S_PAUSE);
    assign done    = (state == S_DONE) || pulse_r;
    assign min_out = min_r;
    assign sec_out = sec_r;

    logic [3:0] sec_u, sec_t, min_u, min_t;
    assign sec_u = 4'(sec_r % 7'd10);
    assign sec_t = 4'(sec_r / 7'd10);
    assign min_u = 4'(min_r % 7'd10);
    assign min_t = 4'(min_r / 7'd10);

    dspl_drv_NexysA7 u_dspl (
        .clock   (clock),
        .reset   (reset),
        .dig1    ({1'b1, sec_u, 1'b0}),
        .dig2    ({1'b1, sec_t, 1'b0}),
        .dig3    ({1'b1, min_u, 1'b1}),
        .dig4    ({1'b1, min_t, 1'b0}),
        .dig5    (6'd0),
        .dig6    (6'd0),
        .dig7    (6'd0),
        .dig8    (6'd0),
        .an      (an),
        .dec_cat (dec_cat)
    );

endmodule

// Eight-digit multiplexed seven-segment driver; each digit field is {enable, value[3:0], dp}.
// Latency: one registered stage from digit field to anode/cathode outputs; scan rate 2^SCAN_W cycles per frame.
// Backpressure: none; fields are sampled continuously, outputs are active-low.

module dspl_drv_NexysA7 #(
    parameter int SCAN_W = 17
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] dig1,
    input  logic [5:0] dig2,
    input  logic [5:0] dig3,
    input  logic [5:0] dig4,
    input  logic [5:0] dig5,
    input  logic [5:0] dig6,
    input  logic [5:0] dig7,
    input  logic [5:0] dig8,
    output logic [7:0] an,
    output logic [7:0] dec_cat
);

    logic [SCAN_W-1:0] scan;
    logic [2:0]        sel;
    logic [5:0]        cur;
    logic [6:0]        seg;

    assign sel = scan[SCAN_W-1 -: 3];

    // Pick the field of the digit currently being scanned.
    always_comb begin
        case (sel)
            3'd0:    cur = dig1;
            3'd1:    cur = dig2;
            3'd2:    cur = dig3;
            3'd3:    cur = dig4;
            3'd4:    cur = dig5;
            3'd5:    cur = dig6;
            3'd6:    cur = dig7;
            default: cur = dig8;
        endcase
    end

    // Hex to active-high segments, bit order g..a.
    always_comb begin
        case (cur[4:1])
            4'h0:    seg = 7'b0111111;
            4'h1:    seg = 7'b0000110;
            4'h2:    seg = 7'b1011011;
            4'h3:    seg = 7'b1001111;
            4'h4:    seg = 7'b1100110;
            4'h5:    seg = 7'b1101101;
            4'h6:    seg = 7'b1111101;
            4'h7:    seg = 7'b0000111;
            4'h8:    seg = 7'b1111111;
            4'h9:    seg = 7'b1101111;
            4'hA:    seg = 7'b1110111;
            4'hB:    seg = 7'b1111100;
            4'hC:    seg = 7'b0111001;
            4'hD:    seg = 7'b1011110;
            4'hE:    seg = 7'b1111001;
            default: seg = 7'b1110001;
        endcase
    end

    // Scan counter and registered active-low anode/cathode drive; disabled digits keep all anodes off.
    always_ff @(posedge clock) begin
        if (reset) begin
            scan    <= '0;
            an      <= 8'hFF;
            dec_cat <= 8'hFF;
        end else begin
            scan    <= scan + 1'b1;
            an      <= cur[5] ? ~(8'b1 << sel) : 8'hFF;
            dec_cat <= {~cur[0], ~seg};
        end
    end

endmodule
